// File: rtl/mem_bram_target_if.sv
// Request/response stream bundle for the memory crossbar ports.
// The master side drives valid and the payload; the slave side drives ready.
interface mem_bram_target_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MASK_WIDTH = DATA_WIDTH / 8
);
    logic                  valid;
    logic                  ready;
    logic                  read_enable;
    logic [MASK_WIDTH-1:0] write_enable;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;

    modport master (output valid, read_enable, write_enable, addr, data, input ready);
    modport slave  (input valid, read_enable, write_enable, addr, data, output ready);
endinterface

// File: rtl/mem_bram_target.sv
// Block-RAM memory target. Requests are executed on a synchronous RAM with a
// READ_LATENCY-deep read pipeline. Read results land in a small response FIFO,
// and a credit counter (reads in flight plus buffered) throttles req.ready, so
// response backpressure can never overflow the FIFO.
module mem_bram_target #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    MASK_WIDTH   = DATA_WIDTH / 8,
    parameter int                    DEPTH        = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
    parameter int                    READ_LATENCY = 2,
    parameter int                    RESP_DEPTH   = READ_LATENCY + 2
) (
    input  logic                     clk,
    input  logic                     rst,
    mem_bram_target_if.slave         req,
    mem_bram_target_if.master        resp,
    output logic [15:0]              err_count
);
    localparam int SHIFT  = $clog2(MASK_WIDTH);
    localparam int BYTE_W = DATA_WIDTH / MASK_WIDTH;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PTR_W  = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int CNT_W  = $clog2(RESP_DEPTH + 1);
    localparam int LAST   = READ_LATENCY - 1;

    // Pointer advance with explicit wrap so non-power-of-2 depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(RESP_DEPTH - 1)) return '0;
        return p + PTR_W'(1);
    endfunction

    logic [DATA_WIDTH-1:0] ram_q [DEPTH];

    logic [ADDR_WIDTH-1:0] offset;
    logic [ADDR_WIDTH-1:0] idx;
    logic [IDX_W-1:0]      ram_idx;
    logic                  in_range;
    logic                  accept;
    logic                  rd_accept;
    logic                  wr_accept;

    logic [READ_LATENCY-1:0] rd_vld_q;
    logic [ADDR_WIDTH-1:0]   rd_addr_q [READ_LATENCY];
    logic                    rd_oob_q  [READ_LATENCY];
    logic [DATA_WIDTH-1:0]   rd_data_q [READ_LATENCY];

    logic [ADDR_WIDTH-1:0] fifo_addr_q [RESP_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data_q [RESP_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      fifo_cnt_q, fifo_cnt_d;
    logic [CNT_W-1:0]      credit_q, credit_d;
    logic [15:0]           err_q, err_d;

    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] push_data;

    // Address decode: byte address to word index, range check against the RAM window.
    assign offset   = req.addr - BASE_ADDR;
    assign idx      = offset >> SHIFT;
    assign in_range = (req.addr >= BASE_ADDR) && (idx < ADDR_WIDTH'(DEPTH));
    assign ram_idx  = idx[IDX_W-1:0];

    // Ready depends only on registered credit, never on resp.ready.
    assign req.ready = !rst && (credit_q < CNT_W'(RESP_DEPTH));
    assign accept    = req.valid && req.ready;
    assign rd_accept = accept && req.read_enable;
    assign wr_accept = accept && in_range && (req.write_enable != '0);

    // Pipeline tail feeds the FIFO; out-of-range reads are forced to zero here.
    assign push      = rd_vld_q[LAST];
    assign push_data = rd_oob_q[LAST] ? '0 : rd_data_q[LAST];
    assign pop       = resp.valid && resp.ready;

    assign resp.valid        = (fifo_cnt_q != '0);
    assign resp.data         = fifo_data_q[rd_ptr_q];
    assign resp.addr         = fifo_addr_q[rd_ptr_q];
    assign resp.read_enable  = 1'b1;
    assign resp.write_enable = '0;
    assign err_count         = err_q;

    // RAM: byte-masked write, registered read (old word on same-beat write), data pipeline.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            for (int i = 0; i < MASK_WIDTH; i++) begin
                if (req.write_enable[i]) ram_q[ram_idx][i*BYTE_W +: BYTE_W] <= req.data[i*BYTE_W +: BYTE_W];
            end
        end
        if (rd_accept) rd_data_q[0] <= ram_q[ram_idx];
        for (int s = 1; s < READ_LATENCY; s++) rd_data_q[s] <= rd_data_q[s-1];
    end

    // Read pipeline valid bits; cleared on reset so in-flight reads are discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld_q <= '0;
        end else begin
            rd_vld_q[0] <= rd_accept;
            for (int s = 1; s < READ_LATENCY; s++) rd_vld_q[s] <= rd_vld_q[s-1];
        end
    end

    // Read pipeline sideband (address, out-of-range flag) kept aligned with RAM output.
    always_ff @(posedge clk) begin
        rd_addr_q[0] <= req.addr;
        rd_oob_q[0]  <= !in_range;
        for (int s = 1; s < READ_LATENCY; s++) begin
            rd_addr_q[s] <= rd_addr_q[s-1];
            rd_oob_q[s]  <= rd_oob_q[s-1];
        end
    end

    // Response FIFO storage.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= push_data;
            fifo_addr_q[wr_ptr_q] <= rd_addr_q[LAST];
        end
    end

    // Next-state for FIFO pointers, occupancy, credits and the error counter.
    always_comb begin
        wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        credit_d   = credit_q;
        err_d      = err_q;
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
        case ({rd_accept, pop})
            2'b10:   credit_d = credit_q + CNT_W'(1);
            2'b01:   credit_d = credit_q - CNT_W'(1);
            default: credit_d = credit_q;
        endcase
        if (accept && !in_range && (err_q != 16'hFFFF)) err_d = err_q + 16'd1;
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            credit_q   <= '0;
            err_q      <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            credit_q   <= credit_d;
            err_q      <= err_d;
        end
    end

    a_no_push_full:  assert property (@(posedge clk) disable iff (rst) !(push && (fifo_cnt_q == CNT_W'(RESP_DEPTH))));
    a_no_pop_empty:  assert property (@(posedge clk) disable iff (rst) !(pop && (fifo_cnt_q == '0)));
    a_credit_bound:  assert property (@(posedge clk) disable iff (rst) credit_q <= CNT_W'(RESP_DEPTH));
endmodule

// File: tb/tb_mem_bram_target.sv
// Bench for mem_bram_target: directed beats with literal expectations plus a
// transaction-level model (word array + queue of pending responses) compared
// against the DUT outputs on every cycle.
module tb_mem_bram_target;
    localparam int          AW    = 32;
    localparam int          DW    = 32;
    localparam int          MW    = 4;
    localparam int          DEPTH = 1024;
    localparam int          L     = 2;
    localparam int          RD    = L + 2;
    localparam logic [31:0] BASE  = 32'h0000_0040;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] err_count;

    always #5 clk = ~clk;

    mem_bram_target_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW)) req_if ();
    mem_bram_target_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW)) resp_if ();

    mem_bram_target #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW), .DEPTH(DEPTH),
        .BASE_ADDR(BASE), .READ_LATENCY(L), .RESP_DEPTH(RD)
    ) dut (
        .clk(clk), .rst(rst), .req(req_if), .resp(resp_if), .err_count(err_count)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          avail;   // response visible in the cycle after this edge number
    } exp_t;

    logic [31:0] mm [DEPTH];
    exp_t        q[$];
    int          cyc    = 0;
    int          m_err  = 0;
    bit          mdl_en = 1'b0;

    function automatic bit in_rng(input logic [31:0] a, output int widx);
        longint off;
        widx = 0;
        if (a < BASE) return 1'b0;
        off  = longint'({32'b0, a}) - longint'({32'b0, BASE});
        widx = int'(off / 4);
        return (off / 4) < DEPTH;
    endfunction

    bit   m_rdy, m_pop, m_ok;
    int   m_idx;
    exp_t m_e;

    always @(posedge clk) begin
        m_rdy = !rst && (q.size() < RD);
        m_pop = !rst && resp_if.ready && (q.size() > 0) && (q[0].avail <= cyc);
        cyc++;
        if (rst) begin
            q.delete();
            m_err  = 0;
            mdl_en = 1'b1;
        end else begin
            if (m_pop) void'(q.pop_front());
            if (req_if.valid && m_rdy) begin
                m_ok = in_rng(req_if.addr, m_idx);
                if (!m_ok && m_err < 65535) m_err++;
                if (req_if.read_enable) begin
                    m_e.addr  = req_if.addr;
                    m_e.data  = m_ok ? mm[m_idx] : 32'h0;
                    m_e.avail = cyc + L;
                    q.push_back(m_e);
                end
                if (m_ok) begin
                    for (int i = 0; i < MW; i++)
                        if (req_if.write_enable[i]) mm[m_idx][i*8 +: 8] = req_if.data[i*8 +: 8];
                end
            end
        end
    end

    // Per-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (mdl_en) begin
            bit exp_v;
            chk("req_ready", req_if.ready, !rst && (q.size() < RD));
            exp_v = (q.size() > 0) && (q[0].avail <= cyc);
            chk("resp_valid", resp_if.valid, exp_v);
            if (exp_v) begin
                chk("resp_data", resp_if.data, q[0].data);
                chk("resp_addr", resp_if.addr, q[0].addr);
                chk("resp_re", resp_if.read_enable, 1'b1);
                chk("resp_we", resp_if.write_enable, 4'h0);
            end
            chk("err_count", err_count, m_err);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic re, input logic [3:0] we, input logic [31:0] a, input logic [31:0] d,
                        output int acc_n);
        int w;
        req_if.valid        = 1'b1;
        req_if.read_enable  = re;
        req_if.write_enable = we;
        req_if.addr         = a;
        req_if.data         = d;
        w = 0;
        @(negedge clk);
        while (!req_if.ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("send_accept", req_if.ready, 1'b1);
        @(posedge clk);
        #1;
        acc_n        = cyc;
        req_if.valid = 1'b0;
    endtask

    task automatic expect_resp(input logic [31:0] exp_d, input logic [31:0] exp_a, input string name,
                               output int vld_n);
        int w;
        w = 0;
        @(negedge clk);
        while (!resp_if.valid && w < 30) begin
            @(negedge clk);
            w++;
        end
        chk({name, "_valid"}, resp_if.valid, 1'b1);
        vld_n = cyc;
        chk({name, "_data"}, resp_if.data, exp_d);
        chk({name, "_addr"}, resp_if.addr, exp_a);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    initial begin
        int a0, a1, vn, acc, first, last, nresp;
        bit r;
        req_if.valid        = 1'b0;
        req_if.read_enable  = 1'b0;
        req_if.write_enable = '0;
        req_if.addr         = '0;
        req_if.data         = '0;
        resp_if.ready       = 1'b1;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Write, partial-mask write, read back with exact latency
        send(1'b0, 4'hF, 32'h100, 32'hDEADBEEF, a0);
        send(1'b0, 4'h2, 32'h100, 32'h0000AA00, a0);
        send(1'b1, 4'h0, 32'h100, 32'h0, a1);
        expect_resp(32'hDEADAAEF, 32'h100, "wr_rd", vn);
        chk("wr_rd_latency", vn - a1, L);

        // Reset held 3 cycles with a write presented: not accepted, RAM intact
        send(1'b0, 4'hF, 32'h80, 32'h12345678, a0);
        rst                 = 1'b1;
        req_if.valid        = 1'b1;
        req_if.read_enable  = 1'b0;
        req_if.write_enable = 4'hF;
        req_if.addr         = 32'h80;
        req_if.data         = 32'hBADBAD00;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_ready_low", req_if.ready, 1'b0);
            if (k == 2) chk("rst_resp_valid_low", resp_if.valid, 1'b0);
            @(posedge clk);
            #1;
        end
        rst          = 1'b0;
        req_if.valid = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", req_if.ready, 1'b1);
        @(posedge clk);
        #1;
        send(1'b1, 4'h0, 32'h80, 32'h0, a0);
        expect_resp(32'h12345678, 32'h80, "rst_no_write", vn);

        // Read-modify-write beat, then a no-op beat that must not write
        send(1'b0, 4'hF, BASE, 32'h11111111, a0);
        send(1'b1, 4'hF, BASE, 32'h22222222, a0);
        send(1'b1, 4'h0, BASE, 32'h0, a0);
        expect_resp(32'h11111111, BASE, "rmw_old", vn);
        expect_resp(32'h22222222, BASE, "rmw_new", vn);
        send(1'b0, 4'h0, BASE, 32'h33333333, a0);
        send(1'b1, 4'h0, BASE, 32'h0, a0);
        expect_resp(32'h22222222, BASE, "nop_beat", vn);

        // Backpressure: credit limit stops acceptance at RD reads
        for (int k = 0; k < 8; k++) send(1'b0, 4'hF, 32'h200 + 4 * k, 32'hA0A0_0000 + k, a0);
        resp_if.ready = 1'b0;
        acc = 0;
        for (int k = 0; k < 8; k++) begin
            req_if.valid        = 1'b1;
            req_if.read_enable  = 1'b1;
            req_if.write_enable = 4'h0;
            req_if.addr         = 32'h200 + 4 * acc;
            req_if.data         = 32'h0;
            @(negedge clk);
            r = req_if.ready;
            @(posedge clk);
            #1;
            if (r) acc++;
        end
        req_if.valid = 1'b0;
        chk("bp_accepted", acc, 4);
        @(negedge clk);
        chk("bp_ready_low", req_if.ready, 1'b0);
        @(posedge clk);
        #1;
        resp_if.ready = 1'b1;
        for (int k = 0; k < 4; k++)
            expect_resp(32'hA0A0_0000 + k, 32'h200 + 4 * k, "bp_resp", vn);
        first = 0;
        last  = 0;
        for (int k = 0; k < 8; k++) begin
            send(1'b1, 4'h0, 32'h200 + 4 * k, 32'h0, a0);
            if (k == 0) first = a0;
            last = a0;
        end
        chk("bp_stream_rate", last - first, 7);
        repeat (10) @(posedge clk);
        #1;

        // Out-of-range read and write
        send(1'b0, 4'hF, BASE + 32'hFFC, 32'hCAFEF00D, a0);
        send(1'b1, 4'h0, BASE + 4 * DEPTH, 32'h0, a0);
        expect_resp(32'h0, BASE + 4 * DEPTH, "oob_read", vn);
        send(1'b0, 4'hF, BASE - 4, 32'hFFFFFFFF, a0);
        send(1'b1, 4'h0, BASE + 32'hFFC, 32'h0, a0);
        expect_resp(32'hCAFEF00D, BASE + 32'hFFC, "oob_ram_intact", vn);
        @(negedge clk);
        chk("oob_err_count", err_count, 16'd2);
        @(posedge clk);
        #1;
        for (int k = 0; k < 70000; k++) send(1'b0, 4'hF, BASE - 4, 32'h0, a0);
        @(negedge clk);
        chk("err_saturated", err_count, 16'hFFFF);
        @(posedge clk);
        #1;

        // Reset with reads in flight: discarded, credits cleared
        resp_if.ready = 1'b0;
        for (int k = 0; k < 3; k++) send(1'b1, 4'h0, 32'h100, 32'h0, a0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst           = 1'b0;
        resp_if.ready = 1'b1;
        nresp = 0;
        repeat (6) begin
            @(negedge clk);
            if (resp_if.valid) nresp++;
        end
        chk("midrst_no_resp", nresp, 0);
        chk("midrst_err_clear", err_count, 16'd0);
        @(posedge clk);
        #1;
        for (int k = 0; k < 6; k++) begin
            send(1'b1, 4'h0, 32'h200 + 4 * k, 32'h0, a0);
            if (k == 0) first = a0;
            last = a0;
        end
        chk("midrst_throughput", last - first, 5);
        repeat (10) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
